vadd_lane_sequencer: RTL

//  Lane-serial controller for the FP16 vector add: accepts a 16-lane x 16-bit operand pair,

---
 rtl/vadd_pkg.sv | 21 ++
 rtl/fp16_add_lane.sv | 71 +++++++
 rtl/vadd_lane_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vadd_pkg.sv
// Shared definitions for the lane-serial FP16 vector adder: geometry defaults,
// binary16 field layout and the sequencer state encoding.
package vadd_pkg;

  localparam int VADD_LANES    = 16;
  localparam int FP16_W        = 16;
  localparam int FP16_SIGN_BIT = 15;
  localparam int FP16_EXP_LSB  = 10;
  localparam int FP16_EXP_W    = 5;
  localparam int FP16_MAN_W    = 10;
  localparam int EXP_BIAS      = 15;

  localparam logic [FP16_W-1:0] FP16_MAX_FINITE = 16'h7BFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/fp16_add_lane.sv
// Combinational binary16 adder: truncating (round toward zero), subnormals
// flushed to +0, overflow saturated to the largest finite value.
module fp16_add_lane
  import vadd_pkg::*;
(
  input  logic [FP16_W-1:0] i_a,
  input  logic [FP16_W-1:0] i_b,
  output logic [FP16_W-1:0] o_sum
);

  // Guard width covers the largest possible exponent gap, so the aligned
  // sum is exact and truncation after normalisation is true round-to-zero.
  localparam int GRD = 31;
  localparam int XW  = FP16_MAN_W + 1 + GRD + 1;

  function automatic logic [5:0] lead_one(input logic [XW-1:0] v);
    logic [5:0] p;
    p = '0;
    for (int i = 0; i < XW; i++) begin
      if (v[i]) p = 6'(i);
    end
    return p;
  endfunction

  logic [FP16_EXP_W-1:0] w_e_a, w_e_b, w_e_big, w_e_sml, w_d;
  logic [FP16_MAN_W:0]   w_m_a, w_m_b, w_m_big, w_m_sml;
  logic                  w_s_big;
  logic [XW-1:0]         w_x_big, w_x_sml, w_x_sum, w_x_nrm;
  logic [5:0]            w_p;
  int                    w_e_res;
  logic                  w_unused;

  always_comb begin
    w_e_a = i_a[FP16_EXP_LSB +: FP16_EXP_W];
    w_e_b = i_b[FP16_EXP_LSB +: FP16_EXP_W];
    w_m_a = (w_e_a == '0) ? '0 : {1'b1, i_a[FP16_MAN_W-1:0]};
    w_m_b = (w_e_b == '0) ? '0 : {1'b1, i_b[FP16_MAN_W-1:0]};

    if ({w_e_a, w_m_a} >= {w_e_b, w_m_b}) begin
      w_s_big = i_a[FP16_SIGN_BIT];
      w_e_big = w_e_a; w_m_big = w_m_a;
      w_e_sml = w_e_b; w_m_sml = w_m_b;
    end else begin
      w_s_big = i_b[FP16_SIGN_BIT];
      w_e_big = w_e_b; w_m_big = w_m_b;
      w_e_sml = w_e_a; w_m_sml = w_m_a;
    end

    w_d     = w_e_big - w_e_sml;
    w_x_big = {1'b0, w_m_big, {GRD{1'b0}}};
    w_x_sml = {1'b0, w_m_sml, {GRD{1'b0}}} >> w_d;
    w_x_sum = (i_a[FP16_SIGN_BIT] ^ i_b[FP16_SIGN_BIT]) ? (w_x_big - w_x_sml)
                                                        : (w_x_big + w_x_sml);

    // Hidden bit of the larger operand sits at XW-2; re-bias the exponent
    // by how far the leading one moved from there.
    w_p     = lead_one(w_x_sum);
    w_x_nrm = w_x_sum << (6'(XW - 1) - w_p);
    w_e_res = int'(w_e_big) + int'(w_p) - (XW - 2);

    if (w_x_sum == '0 || w_e_res <= 0)
      o_sum = '0;
    else if (w_e_res >= (1 << FP16_EXP_W) - 1)
      o_sum = {w_s_big, FP16_MAX_FINITE[FP16_W-2:0]};
    else
      o_sum = {w_s_big, 5'(w_e_res), w_x_nrm[XW-2 -: FP16_MAN_W]};
  end

  assign w_unused = ^{w_x_nrm[XW-1], w_x_nrm[XW-FP16_MAN_W-2:0]};

endmodule

// File: rtl/vadd_lane_sequencer.sv
// Lane-serial FP16 vector add: one shared adder, one lane per cycle.
// Optional performance counters enabled with `define VADD_SEQ_PERF_EN.
module vadd_lane_sequencer
  import vadd_pkg::*;
#(
  parameter int LANES  = VADD_LANES,
  parameter int LANE_W = FP16_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   op_a,
  input  logic [LANES*LANE_W-1:0]   op_b,
  input  logic [$clog2(LANES):0]    lane_cnt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   sum,
  output logic                      busy
`ifdef VADD_SEQ_PERF_EN
  ,
  output logic [31:0]               perf_ops,
  output logic [31:0]               perf_stall
`endif
);

  localparam int IDX_W = $clog2(LANES);
  localparam int CNT_W = IDX_W + 1;

  seq_state_t                    r_state;
  logic [IDX_W-1:0]              r_idx, r_last, r_idx_p1;
  logic                          r_issue, r_vld_p1;
  logic [LANES-1:0][LANE_W-1:0]  r_a, r_b, r_res;
  logic [LANE_W-1:0]             r_sum_p1;
  logic [LANE_W-1:0]             w_sum;
  logic [CNT_W-1:0]              w_n, w_last_n;
  logic                          w_accept, w_retire, w_last_wr, w_unused;

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = !in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_res;
  assign w_accept  = in_valid && in_ready;
  assign w_retire  = out_valid && out_ready;
  assign w_last_wr = r_vld_p1 && (r_idx_p1 == r_last);

  always_comb begin
    w_n = lane_cnt;
    if (lane_cnt == '0 || lane_cnt > CNT_W'(LANES)) w_n = CNT_W'(LANES);
    w_last_n = w_n - CNT_W'(1);
  end
  assign w_unused = w_last_n[CNT_W-1];

  fp16_add_lane u_add (
    .i_a   (r_a[r_idx]),
    .i_b   (r_b[r_idx]),
    .o_sum (w_sum)
  );

  // Stage p0: issue lane r_idx to the adder. Stage p1: write the registered
  // sum into the result vector; DONE follows the write of the last lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_issue  <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_res    <= '0;
    end else begin
      r_vld_p1 <= 1'b0;
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_state <= ST_RUN;
          r_idx   <= '0;
          r_issue <= 1'b1;
          r_res   <= '0;
        end
        ST_RUN: begin
          if (r_issue) begin
            r_vld_p1 <= 1'b1;
            r_idx    <= r_idx + 1'b1;
            if (r_idx == r_last) r_issue <= 1'b0;
          end
          if (r_vld_p1) r_res[r_idx_p1] <= r_sum_p1;
          if (w_last_wr) r_state <= ST_DONE;
        end
        ST_DONE: if (w_retire) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a    <= op_a;
      r_b    <= op_b;
      r_last <= w_last_n[IDX_W-1:0];
    end
    r_sum_p1 <= w_sum;
    r_idx_p1 <= r_idx;
  end

`ifdef VADD_SEQ_PERF_EN
  logic [31:0] r_perf_ops, r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_ops   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_retire) r_perf_ops <= r_perf_ops + 32'd1;
      if (out_valid && !out_ready) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_ops   = r_perf_ops;
  assign perf_stall = r_perf_stall;
`endif

endmodule
